// File: rtl/cordic_mac_pkg.sv
// Shared types and constants for the CORDIC dot-product sequencer.
package cordic_mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUTPUT
  } mac_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 8;

  // Two's-complement bounds of a w-bit signed accumulator.
  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/cordic_sat_acc.sv
// Saturating signed accumulator with clear, enable and sticky overflow flag.
module cordic_sat_acc
  import cordic_mac_pkg::*;
#(
  parameter int IN_W  = DEF_PROD_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  addend,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam longint SMAX = sat_max(ACC_W);
  localparam longint SMIN = sat_min(ACC_W);
  localparam logic [ACC_W-1:0] SMAX_V = SMAX[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SMIN_V = SMIN[ACC_W-1:0];

  logic signed [ACC_W:0] sum;
  longint                sum_l;
  logic [ACC_W-1:0]      nxt;
  logic                  clamp;

  // One guard bit makes the sum exact; clamp back into ACC_W bits.
  always_comb begin
    sum   = $signed({acc[ACC_W-1], acc})
          + $signed({{(ACC_W + 1 - IN_W){addend[IN_W-1]}}, addend});
    sum_l = longint'(sum);
    nxt   = sum[ACC_W-1:0];
    clamp = 1'b0;
    if (sum_l > SMAX) begin
      nxt   = SMAX_V;
      clamp = 1'b1;
    end else if (sum_l < SMIN) begin
      nxt   = SMIN_V;
      clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= nxt;
      ovf <= ovf | clamp;
    end
  end

endmodule

// File: rtl/cordic_mac_sequencer.sv
// Feeds operand pairs to a start/done CORDIC multiplier and accumulates a
// saturating dot product; zero-operand pairs skip the multiplier entirely.
module cordic_mac_sequencer
  import cordic_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_z,
  input  logic              in_last,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_x,
  output logic [DATA_W-1:0] mul_z,
  input  logic [PROD_W-1:0] mul_y,
  input  logic              mul_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  mac_state_t state;
  logic       last_r;
  logic       acc_en;
  logic       acc_clr;
  logic       zero_op;

  // A bypassed pair adds exactly 0, so only multiplied terms enable the adder.
  assign acc_en  = (state == S_ISSUE) && mul_done;
  assign acc_clr = out_valid && out_ready;
  assign zero_op = (in_x == '0) || (in_z == '0);

  cordic_sat_acc #(
    .IN_W  (PROD_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .en     (acc_en),
    .addend (mul_y),
    .acc    (out_acc),
    .ovf    (out_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      mul_start <= 1'b0;
      mul_x     <= '0;
      mul_z     <= '0;
      last_r    <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          mul_x  <= in_x;
          mul_z  <= in_z;
          last_r <= in_last;
          if (out_count != '1) out_count <= out_count + 1'b1;
          if (!zero_op) begin
            state     <= S_ISSUE;
            in_ready  <= 1'b0;
            mul_start <= 1'b1;
          end else if (in_last) begin
            state     <= S_OUTPUT;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        S_ISSUE: if (mul_done) begin
          state     <= S_DRAIN;
          mul_start <= 1'b0;
        end
        // Wait for done to fall so the multiplier sees a start-low gap.
        S_DRAIN: if (!mul_done) begin
          if (last_r) begin
            state     <= S_OUTPUT;
            out_valid <= 1'b1;
          end else begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        S_OUTPUT: if (out_ready) begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          out_count <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_mac_sequencer.sv
// Scoreboard bench: a 24-bit and a 16-bit accumulator instance share one
// stimulus stream and one mock multiplier (their sequencing is identical).
module tb_cordic_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_z = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        mul_done;
  logic [15:0] mul_y;

  logic        in_ready_a, mul_start_a, out_valid_a, ovf_a;
  logic [7:0]  mul_x_a, mul_z_a, cnt_a;
  logic [23:0] acc_a;
  logic        in_ready_b, mul_start_b, out_valid_b, ovf_b;
  logic [7:0]  mul_x_b, mul_z_b, cnt_b;
  logic [15:0] acc_b;

  int checks = 0;
  int errors = 0;
  int lat = 4;
  int pulses = 0;
  logic start_q = 1'b0;

  typedef struct {
    longint acc24;
    longint acc16;
    int     cnt;
    bit     ovf24;
    bit     ovf16;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cordic_mac_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_x(in_x), .in_z(in_z), .in_last(in_last), .mul_start(mul_start_a),
    .mul_x(mul_x_a), .mul_z(mul_z_a), .mul_y(mul_y), .mul_done(mul_done),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(acc_a),
    .out_count(cnt_a), .out_ovf(ovf_a)
  );

  cordic_mac_sequencer #(.ACC_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_x(in_x), .in_z(in_z), .in_last(in_last), .mul_start(mul_start_b),
    .mul_x(mul_x_b), .mul_z(mul_z_b), .mul_y(mul_y), .mul_done(mul_done),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(acc_b),
    .out_count(cnt_b), .out_ovf(ovf_b)
  );

  // Mock exact multiplier: done after lat cycles of start, held until start falls.
  int mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
      mul_done <= 1'b0;
      mul_y <= '0;
    end else if (!mul_start_a) begin
      mcnt <= 0;
      mul_done <= 1'b0;
    end else if (!mul_done) begin
      if (mcnt == lat - 1) begin
        mul_done <= 1'b1;
        mul_y <= $signed({{8{mul_x_a[7]}}, mul_x_a}) * $signed({{8{mul_z_a[7]}}, mul_z_a});
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mul_start_a && !start_q) pulses++;
    start_q = mul_start_a;
  end

  // Monitor: compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("acc24", longint'($signed(acc_a)), e.acc24);
        chk("ovf24", longint'(ovf_a), longint'(e.ovf24));
        chk("count24", longint'(cnt_a), longint'(e.cnt));
        chk("valid16", longint'(out_valid_b), 1);
        chk("acc16", longint'($signed(acc_b)), e.acc16);
        chk("ovf16", longint'(ovf_b), longint'(e.ovf16));
        chk("count16", longint'(cnt_b), longint'(e.cnt));
      end
    end
  end

  task automatic expect_out(input longint a24, input longint a16, input int c,
                            input bit o24, input bit o16);
    exp_t e;
    e.acc24 = a24; e.acc16 = a16; e.cnt = c; e.ovf24 = o24; e.ovf16 = o16;
    sb.push_back(e);
  endtask

  task automatic send(input logic signed [7:0] x, input logic signed [7:0] z, input bit last);
    bit ok = 0;
    in_x = x; in_z = z; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready_a) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x = 8'h5a;  // later input changes must be ignored
    in_z = 8'ha5;
    in_last = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 500; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      chk(name, longint'(sb.size()), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_in_ready", longint'(in_ready_a), 1);
    chk("rst_mul_start", longint'(mul_start_a), 0);
    chk("rst_mul_x", longint'(mul_x_a), 0);
    chk("rst_out_valid", longint'(out_valid_a), 0);
    chk("rst_acc", longint'(acc_a), 0);
    chk("rst_count_ovf", longint'({cnt_a, ovf_a}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 12 - 30 - 56 = -74
    lat = 4; pulses = 0;
    expect_out(-74, -74, 3, 0, 0);
    send(3, 4, 0); send(-5, 6, 0); send(7, -8, 1);
    wait_empty("t1_timeout");
    chk("t1_pulses", pulses, 3);

    // 2: zero operands bypass the multiplier
    lat = 2; pulses = 0;
    expect_out(4, 4, 3, 0, 0);
    send(0, 100, 0); send(-128, 0, 0); send(2, 2, 1);
    wait_empty("t2_timeout");
    chk("t2_pulses", pulses, 1);

    // 3: 3*16129 = 48387 clamps to 32767 in 16 bits; then clean vector
    lat = 1;
    expect_out(48387, 32767, 3, 0, 1);
    send(127, 127, 0); send(127, 127, 0); send(127, 127, 1);
    wait_empty("t3_timeout");
    expect_out(1, 1, 1, 0, 0);
    send(1, 1, 1);
    wait_empty("t3b_timeout");

    // 4: output back-pressure with a pending input
    lat = 3;
    out_ready = 1'b0;
    send(5, 5, 1);
    for (int i = 0; i < 100 && !out_valid_a; i++) @(negedge clk);
    in_x = 9; in_z = 9; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_valid_held", longint'(out_valid_a), 1);
      chk("t4_acc_held", longint'($signed(acc_a)), 25);
      chk("t4_in_ready_low", longint'(in_ready_a), 0);
    end
    expect_out(25, 25, 1, 0, 0);
    expect_out(81, 81, 1, 0, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(9, 9, 1);
    wait_empty("t4_timeout");

    // 5: extreme operands
    lat = 20;
    expect_out(16384, 16384, 1, 0, 0);
    send(-128, -128, 1);
    wait_empty("t5a_timeout");
    expect_out(-16256, -16256, 1, 0, 0);
    send(127, -128, 1);
    wait_empty("t5b_timeout");

    // 6: reset during ISSUE
    lat = 10;
    send(6, 6, 0);
    send(3, 3, 1);
    repeat (3) @(negedge clk);
    chk("t6_issue_start", longint'(mul_start_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_start", longint'(mul_start_a), 0);
    chk("t6_rst_in_ready", longint'(in_ready_a), 1);
    chk("t6_rst_acc", longint'(acc_a), 0);
    chk("t6_rst_count", longint'(cnt_a), 0);
    chk("t6_rst_mul_xz", longint'({mul_x_a, mul_z_a}), 0);
    chk("t6_rst_valid", longint'(out_valid_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out(-2, -2, 2, 0, 0);
    send(-3, 4, 0); send(2, 5, 1);
    wait_empty("t6_timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_mac_sequencer.md
# cordic_mac_sequencer

Sequencer and accumulator placed directly around the 8-bit CORDIC multiplier (start/done interface, signed x/z in, 16-bit product out). It accepts a stream of signed operand pairs over valid/ready and issues each pair to the multiplier. It accumulates the returned products into a saturating dot-product sum and presents the result on a valid/ready output when the pair flagged `in_last` has been consumed. Pairs with a zero operand bypass the multiplier, which saves the multi-cycle CORDIC latency and guarantees an exact 0 term.

## Interface
- `DATA_W`, 8: operand width; must match the multiplier x/z width.
- `PROD_W`, 16: multiplier product width (2*DATA_W).
- `ACC_W`, 24: accumulator width; must be ≥ PROD_W.
- `CNT_W`, 8: element counter width.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can accept a pair.
- `in_x` in DATA_W: signed multiplicand.
- `in_z` in DATA_W: signed multiplier.
- `in_last` in 1: final pair of the current vector.
- `mul_start` out 1: multiplier start; level-held until done is seen.
- `mul_x` out DATA_W: registered operand to the multiplier.
- `mul_z` out DATA_W: registered operand to the multiplier.
- `mul_y` in PROD_W: product, interpreted as signed.
- `mul_done` in 1: multiplier done; level, held while start is high.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_acc` out ACC_W: signed saturated sum.
- `out_count` out CNT_W: number of pairs in the vector; saturates at all-ones.
- `out_ovf` out 1: sticky flag, set if any accumulation saturated.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - ISSUE: `mul_start`=1.
  - DRAIN: `mul_start`=0, waiting for `mul_done`=0.
  - OUTPUT: `out_valid`=1.
- IDLE, on `in_valid && in_ready`:
  - Register x, z and last. Increment the count.
  - If x==0 or z==0, add 0 (no multiplier activity), then go to OUTPUT if last, else stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE: hold `mul_start`, `mul_x` and `mul_z` stable. On an edge where `mul_done`=1, add sign-extended `mul_y` to the accumulator and go to DRAIN.
- DRAIN: `mul_start`=0. On an edge where `mul_done`=0, go to OUTPUT if last, else to IDLE. This enforces a start-low gap between operations.
- OUTPUT:
  - Hold `out_acc`, `out_count` and `out_ovf` stable; `in_ready`=0.
  - On `out_valid && out_ready`, clear the accumulator, count and ovf, then go to IDLE.
- Accumulation:
  - Compute at ACC_W+1 bits and clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - A clamp sets ovf, which stays set until the output handshake.
  - Default widths cannot overflow for ≤255 terms.
- `in_x`/`in_z` are sampled only at acceptance; later input changes are ignored.
- `mul_y` is ignored outside ISSUE.

## Timing
- Reset values: IDLE, `in_ready`=1, `mul_start`=0, `mul_x`=`mul_z`=0, `out_valid`=0, `out_acc`=0, `out_count`=0, `out_ovf`=0.
- `mul_start` rises on the edge after acceptance.
- Per multiplied pair: acceptance (1 cycle) + L (multiplier latency) + DRAIN (≥1 cycle).
- Per bypassed pair: 1 cycle.
- `out_valid` rises on the edge after the last term is accumulated.
- `out_valid` is never combinationally dependent on `out_ready`.
- `in_ready` is a registered state decode: 0 in ISSUE, DRAIN and OUTPUT.
- Reset mid-operation clears everything immediately, with `mul_start` forced to 0. The multiplier is expected to abort on `start` low.

## Structure
- Package `cordic_mac_pkg`:
  - state enum `mac_state_t`;
  - default width localparams;
  - saturation bound constants as functions of ACC_W.
- Sub-module `cordic_sat_acc`: saturating signed adder plus register, with clear, enable and ovf output.
- The multiplier is instantiated only in the bench/top, never inside this block.

## Test plan
The bench uses a mock exact multiplier with configurable latency L (1..20); done is held until start falls.
1. Pairs (3,4), (−5,6), (7,−8,last), L=4 → `out_acc`=−74, `out_count`=3, `out_ovf`=0; exactly three `mul_start` pulses.
2. Pairs (0,100), (−128,0), (2,2,last) → one `mul_start` pulse only; `out_acc`=4, `out_count`=3.
3. ACC_W=16, three pairs (127,127) with the last flagged → `out_acc`=32767, `out_ovf`=1. Next vector (1,1,last) → `out_acc`=1, `out_ovf`=0.
4. `out_ready` low for 10 cycles with `in_valid` held on (9,9) → `out_valid` and `out_acc` stable, `in_ready`=0 throughout, and (9,9) is accepted only after the output handshake.
5. Single pair (−128,−128,last) → `out_acc`=16384. Single pair (127,−128,last) → `out_acc`=−16256.
6. Assert `rst_n` low during ISSUE (L=10) → `mul_start` goes to 0 asynchronously and all outputs take reset values. After release, `in_ready`=1 and a fresh vector computes correctly.
